// File: rtl/mix_columns_sequencer.sv
// mix_columns_sequencer
//   Sequences one shared 4-byte AES MixColumns multiplier (02/03/01/01 matrix)
//   over the four columns of a 128-bit state, one column per cycle, then holds
//   the reassembled result under valid/ready backpressure. A bypass input passes
//   the state through untouched for the final round.
//
// Ports
//   clk        : clock, rising edge
//   reset      : synchronous active-high reset
//   in_valid   : in_state/in_bypass valid
//   in_ready   : block accepts a state (IDLE only)
//   in_state   : 128-bit state, column c = in_state[127-32c -: 32], top byte MSB
//   in_bypass  : 1 = pass state through unchanged
//   out_valid  : out_state holds a completed result
//   out_ready  : downstream accepts out_state
//   out_state  : 128-bit result, same ordering as in_state
//   busy       : high in RUN or DONE
//   col_idx    : column being multiplied, 0 outside RUN
module mix_columns_sequencer (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_bypass,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy,
    output logic [1:0]   col_idx
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    col_q, col_d;
    logic [127:0]  work_q, work_d;
    logic [127:0]  out_q, out_d;
    logic [31:0]   col_in, col_out;
    logic [6:0]    col_lsb;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        xtime = {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] c);
        logic [7:0] b0, b1, b2, b3;
        b0 = c[31:24];
        b1 = c[23:16];
        b2 = c[15:8];
        b3 = c[7:0];
        mix_column = {xtime(b0) ^ xtime(b1) ^ b1 ^ b2 ^ b3,
                      xtime(b1) ^ xtime(b2) ^ b2 ^ b3 ^ b0,
                      xtime(b2) ^ xtime(b3) ^ b3 ^ b0 ^ b1,
                      xtime(b3) ^ xtime(b0) ^ b0 ^ b1 ^ b2};
    endfunction

    // Column c occupies bits [32*(3-c) +: 32]; 3-c is just ~c on two bits.
    assign col_lsb = {~col_q, 5'b0_0000};
    assign col_in  = work_q[col_lsb +: 32];
    assign col_out = mix_column(col_in);

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        work_d  = work_q;
        out_d   = out_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (in_bypass) begin
                        out_d   = in_state;
                        state_d = ST_DONE;
                    end else begin
                        work_d  = in_state;
                        col_d   = 2'd0;
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                work_d[col_lsb +: 32] = col_out;
                col_d = col_q + 2'd1;
                if (col_q == 2'd3) begin
                    // Final column lands in the output register on the same edge.
                    out_d   = work_d;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            col_q   <= '0;
            work_q  <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            work_q  <= work_d;
            out_q   <= out_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign out_valid = (state_q == ST_DONE);
    assign out_state = out_q;
    assign col_idx   = (state_q == ST_RUN) ? col_q : 2'd0;

endmodule
